// File: rtl/mdu_ctrl.sv
// Purpose: multi-cycle mult/div sequencer owning HI/LO; also executes mthi/mtlo.
// Latency: mult/multu MULT_CYCLES, div/divu DIV_CYCLES after issue; mthi/mtlo same edge.
// Backpressure: stall_md holds D-stage HI/LO users from the issue cycle until after commit.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        D_use_md,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_q;       // only mult/multu/div/divu ever get latched
    logic [31:0]      a_q, b_q;
    logic [31:0]      hi_q, lo_q;

    logic             issue, commit, div_by_zero;
    logic [63:0]      prod_s, prod_u, res;
    logic [31:0]      abs_a, abs_b, q_mag, r_mag, q_s, r_s;

    assign issue       = (state == IDLE) && start && !md_op[2];
    assign commit      = (state == BUSY) && (cnt == CNT_ONE);
    assign div_by_zero = op_q[1] && (b_q == 32'd0);

    assign busy     = (state == BUSY);
    assign stall_md = D_use_md & (busy | start);
    assign hi       = hi_q;
    assign lo       = lo_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: leave IDLE on an arithmetic issue, return on the final count.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue)  state_nxt = BUSY;
            BUSY:    if (commit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result from the latched operands; only sampled on the commit edge.
    always_comb begin
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        // Signed divide via magnitudes; -2^31 magnitude stays 0x80000000 as unsigned.
        abs_a  = a_q[31] ? (32'd0 - a_q) : a_q;
        abs_b  = b_q[31] ? (32'd0 - b_q) : b_q;
        q_mag  = abs_a / abs_b;
        r_mag  = abs_a % abs_b;
        q_s    = (a_q[31] ^ b_q[31]) ? (32'd0 - q_mag) : q_mag;
        r_s    = a_q[31] ? (32'd0 - r_mag) : r_mag;
        case (op_q)
            2'd0:    res = prod_s;
            2'd1:    res = prod_u;
            2'd2:    res = {r_s, q_s};
            default: res = {a_q % b_q, a_q / b_q};
        endcase
    end

    // Operand latch and busy countdown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (issue) begin
            cnt  <= md_op[1] ? DIV_LAT : MULT_LAT;
            op_q <= md_op[1:0];
            a_q  <= rs_val;
            b_q  <= rt_val;
        end else if (state == BUSY) begin
            cnt  <= cnt - CNT_ONE;
        end
    end

    // HI/LO: arithmetic commit at end of BUSY, mthi/mtlo immediately when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (commit) begin
            if (!div_by_zero) begin
                hi_q <= res[63:32];
                lo_q <= res[31:0];
            end
        end else if ((state == IDLE) && start) begin
            if (md_op == 3'd4) hi_q <= rs_val;
            if (md_op == 3'd5) lo_q <= rs_val;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Purpose: directed plus randomized check of mdu_ctrl against an arithmetic model.
// Latency: expects busy for exactly the op latency, HI/LO update on the final edge.
// Backpressure: checks stall_md on the issue cycle, through busy, and after commit.
module tb_mdu_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val, rt_val;
    logic        D_use_md;
    logic        busy, stall_md;
    logic [31:0] hi, lo;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .D_use_md (D_use_md),
        .busy     (busy),
        .stall_md (stall_md),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Architectural meaning of each op, written with wide integer arithmetic.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: begin p = 64'(sa * sb); exp_hi = p[63:32]; exp_lo = p[31:0]; end
            3'd1: begin p = 64'(ua * ub); exp_hi = p[63:32]; exp_lo = p[31:0]; end
            3'd2: if (b != 0) begin exp_lo = 32'(sa / sb); exp_hi = 32'(sa % sb); end
            3'd3: if (b != 0) begin exp_lo = 32'(ua / ub); exp_hi = 32'(ua % ub); end
            3'd4: exp_hi = a;
            3'd5: exp_lo = a;
            default: ;
        endcase
    endfunction

    // Issue one op and follow it to completion; poke drives a stray start mid-BUSY.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic duse, input bit poke);
        int          lat;
        logic [31:0] old_hi, old_lo;
        old_hi = exp_hi;
        old_lo = exp_lo;
        lat = (op <= 3'd1) ? MC : (op <= 3'd3) ? DC : 0;
        @(negedge clk);
        start = 1'b1; md_op = op; rs_val = a; rt_val = b; D_use_md = duse;
        #1;
        chk("stall_issue", 32'(stall_md), 32'(duse));
        chk("busy_issue", 32'(busy), 32'd0);
        model(op, a, b);
        @(posedge clk);
        #1;
        start = 1'b0; rs_val = $urandom; rt_val = $urandom;
        if (lat == 0) begin
            chk("busy_imm", 32'(busy), 32'd0);
            chk("hi_imm", hi, exp_hi);
            chk("lo_imm", lo, exp_lo);
        end else begin
            for (int i = 0; i < lat; i++) begin
                @(negedge clk);
                chk("busy_run", 32'(busy), 32'd1);
                chk("stall_run", 32'(stall_md), 32'(duse));
                chk("hi_hold", hi, old_hi);
                chk("lo_hold", lo, old_lo);
                if (poke && i == 1) begin
                    start = 1'b1; md_op = 3'($urandom_range(0, 5));
                end
                if (poke && i == 2) start = 1'b0;
            end
            @(negedge clk);
            chk("busy_done", 32'(busy), 32'd0);
            chk("stall_done", 32'(stall_md), 32'd0);
            chk("hi_commit", hi, exp_hi);
            chk("lo_commit", lo, exp_lo);
        end
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        reset = 1'b1; start = 1'b0; md_op = '0; rs_val = '0; rt_val = '0; D_use_md = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_stall", 32'(stall_md), 32'd0);

        do_op(3'd0, 32'hFFFFFFFE, 32'd3, 1'b1, 1'b0);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFA);

        do_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        do_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
        chk("divu_lo", lo, 32'h7FFFFFFC);
        chk("divu_hi", hi, 32'd1);

        do_op(3'd4, 32'h11, 32'd0, 1'b0, 1'b0);
        do_op(3'd5, 32'h22, 32'd0, 1'b0, 1'b0);
        do_op(3'd2, 32'd5, 32'd0, 1'b1, 1'b0);
        chk("dz_hi", hi, 32'h11);
        chk("dz_lo", lo, 32'h22);
        do_op(3'd5, 32'h5, 32'd0, 1'b0, 1'b0);
        chk("mtlo_lo", lo, 32'h5);
        chk("mtlo_hi", hi, 32'h11);

        do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        chk("ovf_lo", lo, 32'h80000000);
        chk("ovf_hi", hi, 32'd0);

        do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);

        // Stray start during BUSY must not disturb count or result.
        do_op(3'd0, $urandom, $urandom, 1'b1, 1'b1);
        do_op(3'd3, $urandom, $urandom, 1'b0, 1'b1);

        // Async reset three cycles into a divide, mid-cycle.
        do_op(3'd4, 32'hCAFE0001, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; md_op = 3'd2; rs_val = 32'd100; rt_val = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (DC + 2) @(negedge clk);
        chk("post_rst_hi", hi, 32'd0);
        chk("post_rst_lo", lo, 32'd0);

        // Randomized ops with special operand values mixed in.
        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       ra = 32'h80000000;
                1:       ra = 32'hFFFFFFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = 32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            do_op(rop, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide sequencer for the 5-stage MIPS pipeline; owns the HI/LO registers.
- E-stage issues mult/multu/div/divu/mthi/mtlo through `start`.
- Holds HI/LO busy for a fixed latency, then commits the result.
- Drives a stall request into the hazard/stall controller so D-stage HI/LO users wait while the unit is occupied.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  E-stage instruction is an MD op and E is valid (not cleared)
- md_op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 reserved (ignored)
- rs_val  in  32  forwarded E-stage rs operand
- rt_val  in  32  forwarded E-stage rt operand
- D_use_md  in  1  D-stage instruction is mfhi/mflo/mult/multu/div/divu/mthi/mtlo
- busy  out  1  multi-cycle operation in progress
- stall_md  out  1  stall request to hazard unit
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset, async: state=IDLE, cnt=0, hi=0, lo=0, busy=0, latched operands/op=0.
- States: IDLE and BUSY. busy = (state==BUSY), registered.
- IDLE, start=1, md_op in 0..3, at edge k:
  - Latch rs_val, rt_val, md_op.
  - cnt <= MULT_CYCLES or DIV_CYCLES (LAT); state <= BUSY.
- BUSY, each edge: cnt <= cnt-1. When cnt==1 at an edge: commit HI/LO and go to IDLE.
- Timing: busy is high for exactly LAT cycles after edge k; hi/lo change at edge k+LAT; busy low after it.
- hi/lo hold their old value throughout BUSY.
- mthi/mtlo (start=1, md_op 4/5) in IDLE: hi<=rs_val or lo<=rs_val at the same edge; no BUSY; other register unchanged.
- Reserved md_op with start=1: no effect.
- start=1 while BUSY: ignored, state and cnt unaffected. The hazard unit must prevent this.
- stall_md = D_use_md & (busy | start), combinational.
  - Covers the issue cycle, before busy rises.
  - Deasserts in the cycle after the commit edge, so a stalled mfhi reads the committed value.
- Arithmetic:
  - mult: {hi,lo} = signed 64-bit rs*rt.
  - multu: unsigned 64-bit rs*rt.
  - div: lo = quotient truncated toward zero, hi = remainder with sign of dividend; -2^31 / -1 gives lo=0x80000000, hi=0.
  - divu: unsigned quotient/remainder.
- Divide by zero: full DIV_CYCLES busy, then hi/lo unchanged.
- Result may be computed at issue or at commit from latched operands; only the commit-edge value is architected.
- Reset mid-BUSY: returns to IDLE immediately, hi=lo=0, no commit.
- Pipeline E_clr does not cancel an issued op. start is sampled only at the issue edge.

Test Plan:
- Reset, then IDLE: busy=0, hi=lo=0, stall_md=0 with D_use_md=1.
- mult rs=0xFFFFFFFE (-2), rt=3, D_use_md=1 (mflo): stall_md=1 on issue cycle plus 5 busy cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFA after edge k+5; stall_md=0 the next cycle.
- div rs=0xFFFFFFF9 (-7), rt=2: busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu same operands: lo=0x7FFFFFFC, hi=1.
- Divide by zero, hi=0x11 and lo=0x22 preloaded via mthi/mtlo: busy 10 cycles, hi/lo still 0x11/0x22. mtlo rs=0x5: lo=5 at the same edge, busy stays 0.
- Special cases:
  - div 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - multu 0xFFFFFFFF*0xFFFFFFFF gives hi=0xFFFFFFFE, lo=0x00000001.
- Async reset asserted mid-cycle, 3 cycles into a div: busy=0, hi=lo=0 immediately without a clock edge; a second start while BUSY (no reset) leaves cnt and result unchanged.
